// File: rtl/gppcu_pkg.sv
// Shared definitions for the GPPCU core and its instruction dispatcher:
// datapath width, dispatcher state encoding and instruction field positions.
package gppcu_pkg;

    localparam int DBW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dispState_e;

    // Instruction field offsets, kept in step with the core decoder.
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = 6;
    localparam int RD_LSB     = 21;
    localparam int RS_LSB     = 16;
    localparam int REG_W      = 5;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = 16;

endpackage

// File: rtl/gppcu_dispatch_fifo.sv
// Two-entry valid/ready FIFO. The head entry drives the outputs directly from
// flops, so rdValid/rdData never depend combinationally on rdReady.
module gppcu_dispatch_fifo #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wrData,
    input  logic          wrEn,
    output logic [DW-1:0] rdData,
    output logic          rdValid,
    input  logic          rdReady,
    output logic [1:0]    level
);

    logic [DW-1:0] headData_r;
    logic [DW-1:0] tailData_r;
    logic          headValid_r;
    logic          tailValid_r;
    logic          pop_s;

    assign pop_s   = headValid_r & rdReady;
    assign rdData  = headData_r;
    assign rdValid = headValid_r;
    assign level   = {tailValid_r, headValid_r & ~tailValid_r};

    // Head/tail update: pop promotes the tail, push fills the first free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headData_r  <= '0;
            tailData_r  <= '0;
            headValid_r <= 1'b0;
            tailValid_r <= 1'b0;
        end else if (pop_s) begin
            if (tailValid_r) begin
                headData_r  <= tailData_r;
                headValid_r <= 1'b1;
                tailValid_r <= wrEn;
                if (wrEn) begin
                    tailData_r <= wrData;
                end
            end else begin
                headValid_r <= wrEn;
                if (wrEn) begin
                    headData_r <= wrData;
                end
            end
        end else if (!headValid_r) begin
            headValid_r <= wrEn;
            if (wrEn) begin
                headData_r <= wrData;
            end
        end else if (wrEn && !tailValid_r) begin
            tailData_r  <= wrData;
            tailValid_r <= 1'b1;
        end
    end

endmodule

// File: rtl/gppcu_instr_dispatcher.sv
// Streams a program-RAM segment to the GPPCU instruction port with back-pressure.
// Optional GPPCU_DISPATCH_LOOP_EN repeats the segment iLOOP_COUNT+1 times.
module gppcu_instr_dispatcher #(
    parameter int DBW     = gppcu_pkg::DBW,
    parameter int PROG_AW = 8
) (
    input  logic               iACLK,
    input  logic               iARST,
    input  logic [PROG_AW-1:0] iPROG_ADDR,
    input  logic [DBW-1:0]     iPROG_WDATA,
    input  logic               iPROG_WR,
    input  logic               iSTART,
    input  logic [PROG_AW-1:0] iSTART_ADDR,
    input  logic [PROG_AW:0]   iINSTR_COUNT,
`ifdef GPPCU_DISPATCH_LOOP_EN
    input  logic [7:0]         iLOOP_COUNT,
`endif
    output logic [DBW-1:0]     oINSTR,
    output logic               oINSTR_VALID,
    input  logic               iINSTR_READY,
    output logic               oBUSY,
    output logic               oDONE
);
    import gppcu_pkg::*;

    logic [DBW-1:0]     progRam_r [2**PROG_AW];
    logic [DBW-1:0]     ramData_r;
    logic               inFlight_r;
    logic [PROG_AW-1:0] readAddr_r;
    logic [PROG_AW:0]   remaining_r;
    dispState_e         state_r;
    dispState_e         nextState_s;
    logic               busy_r;
    logic               done_r;
    logic               zeroPend_r;
    logic               pop_s;
    logic               issue_s;
    logic               lastRead_s;
    logic               reload_s;
    logic               finalPass_s;
    logic               accept_s;
    logic               startZero_s;
    logic               drainDone_s;
    logic [1:0]         fifoLevel_s;
    logic [1:0]         occEff_s;

`ifdef GPPCU_DISPATCH_LOOP_EN
    logic [PROG_AW-1:0] startAddr_r;
    logic [PROG_AW:0]   count_r;
    logic [7:0]         passLeft_r;
    assign finalPass_s = (passLeft_r == 8'd0);
`else
    assign finalPass_s = 1'b1;
`endif

    assign pop_s  = oINSTR_VALID & iINSTR_READY;
    assign oBUSY  = busy_r;
    assign oDONE  = done_r;

    // Read issue: a slot freed by this cycle's transfer counts as free, so a
    // stream with ready held high runs without bubbles.
    always_comb begin
        occEff_s    = fifoLevel_s - {1'b0, pop_s};
        accept_s    = 1'b0;
        startZero_s = 1'b0;
        issue_s     = 1'b0;
        if (state_r == IDLE && iSTART) begin
            accept_s    = (iINSTR_COUNT != '0);
            startZero_s = (iINSTR_COUNT == '0);
        end else begin
            accept_s    = 1'b0;
            startZero_s = 1'b0;
        end
        if (state_r == RUN && remaining_r != '0 && (occEff_s + {1'b0, inFlight_r}) < 2'd2) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        lastRead_s  = issue_s && (remaining_r == (PROG_AW+1)'(1)) && finalPass_s;
        reload_s    = issue_s && (remaining_r == (PROG_AW+1)'(1)) && !finalPass_s;
        drainDone_s = (state_r == DRAIN) && pop_s && (fifoLevel_s == 2'd1) && !inFlight_r;
    end

    // Next-state decode.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE:    if (accept_s)    nextState_s = RUN;   else nextState_s = IDLE;
            RUN:     if (lastRead_s)  nextState_s = DRAIN; else nextState_s = RUN;
            DRAIN:   if (drainDone_s) nextState_s = IDLE;  else nextState_s = DRAIN;
            default: nextState_s = IDLE;
        endcase
    end

    // Control registers; reset cancels any read in flight.
    always_ff @(posedge iACLK or posedge iARST) begin
        if (iARST) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            zeroPend_r  <= 1'b0;
            inFlight_r  <= 1'b0;
            readAddr_r  <= '0;
            remaining_r <= '0;
`ifdef GPPCU_DISPATCH_LOOP_EN
            startAddr_r <= '0;
            count_r     <= '0;
            passLeft_r  <= 8'd0;
`endif
        end else begin
            state_r    <= nextState_s;
            busy_r     <= (nextState_s != IDLE);
            done_r     <= zeroPend_r | drainDone_s;
            zeroPend_r <= startZero_s;
            inFlight_r <= issue_s;
            if (accept_s) begin
                readAddr_r  <= iSTART_ADDR;
                remaining_r <= iINSTR_COUNT;
`ifdef GPPCU_DISPATCH_LOOP_EN
                startAddr_r <= iSTART_ADDR;
                count_r     <= iINSTR_COUNT;
                passLeft_r  <= iLOOP_COUNT;
            end else if (reload_s) begin
                readAddr_r  <= startAddr_r;
                remaining_r <= count_r;
                passLeft_r  <= passLeft_r - 8'd1;
`endif
            end else if (issue_s) begin
                readAddr_r  <= readAddr_r + PROG_AW'(1);
                remaining_r <= remaining_r - (PROG_AW+1)'(1);
            end
        end
    end

    // Program RAM: host writes only while idle; synchronous read feeds the FIFO.
    always_ff @(posedge iACLK) begin
        if (iPROG_WR && !busy_r) begin
            progRam_r[iPROG_ADDR] <= iPROG_WDATA;
        end
        if (issue_s) begin
            ramData_r <= progRam_r[readAddr_r];
        end
    end

    gppcu_dispatch_fifo #(.DW(DBW)) uFifo (
        .clk     (iACLK),
        .rst     (iARST),
        .wrData  (ramData_r),
        .wrEn    (inFlight_r),
        .rdData  (oINSTR),
        .rdValid (oINSTR_VALID),
        .rdReady (iINSTR_READY),
        .level   (fifoLevel_s)
    );

endmodule

// File: doc/gppcu_instr_dispatcher.md
# gppcu_instr_dispatcher

Instruction issuer that drives the GPPCU core's instruction port, as the initiator of the `iINSTR`/`iINSTR_VALID`/`oINSTR_READY` handshake. The host loads a program into an internal program RAM and then starts a run of N instructions from a start address. The dispatcher streams those instructions to the core at up to one per clock, honouring core back-pressure, and signals completion.

## Interface
Parameters:
- `DBW`, 32, instruction width.
- `PROG_AW`, 8, program RAM address width; depth is 2^PROG_AW.

Ports:
- `iACLK` in 1: clock. One clock domain; reset is asynchronous and active-high.
- `iARST` in 1: asynchronous active-high reset.
- `iPROG_ADDR` in PROG_AW: program RAM write address.
- `iPROG_WDATA` in DBW: program RAM write data.
- `iPROG_WR` in 1: program RAM write strobe.
- `iSTART` in 1: start a run (single-cycle pulse).
- `iSTART_ADDR` in PROG_AW: first instruction address; sampled with `iSTART`.
- `iINSTR_COUNT` in PROG_AW+1: number of instructions to issue; sampled with `iSTART`.
- `oINSTR` out DBW: instruction to the core.
- `oINSTR_VALID` out 1: `oINSTR` is valid.
- `iINSTR_READY` in 1: the core accepts the instruction.
- `oBUSY` out 1: a run is in progress.
- `oDONE` out 1: one-cycle pulse at the end of a run.

## Operation
- States are `IDLE`, `RUN` and `DRAIN`.
- **IDLE → RUN:** on `iSTART`=1 while in `IDLE`. The dispatcher latches the address and count.
  - Exception: if `iINSTR_COUNT`=0, the next state is `IDLE`, `oDONE` pulses, and `oINSTR_VALID` is never asserted.
- **RUN:**
  - The program RAM is a synchronous read with 1-cycle latency.
  - Read data feeds a 2-entry output FIFO.
  - A read is issued when (FIFO occupancy + reads in flight) < 2 and reads remaining > 0.
  - The read address increments modulo 2^PROG_AW, so it wraps from the top of RAM to 0.
- **RUN → DRAIN:** when the last read has been issued.
- **DRAIN → IDLE:** on the handshake of the last instruction. `oDONE`=1 for exactly that next cycle.
- **Handshake:** a transfer occurs on a clock edge where `oINSTR_VALID`=1 and `iINSTR_READY`=1.
  - Once `oINSTR_VALID` is asserted, it and `oINSTR` stay stable until the transfer.
  - `oINSTR_VALID` is never combinationally dependent on `iINSTR_READY`.
- **Ordering:** exactly `iINSTR_COUNT` transfers, in address order.
- **Ignored inputs:**
  - `iSTART` is ignored while `oBUSY`=1.
  - `iPROG_WR` is ignored (write dropped) while `oBUSY`=1.
- **Same-cycle write and start in IDLE:** the write commits first, so a run started in the same cycle reads the new data.
- **Reset:** at any time, including mid-run, reset returns to `IDLE`, flushes the FIFO and cancels in-flight reads. RAM contents are not reset.

## Timing
- Reset values: `oINSTR`=0, `oINSTR_VALID`=0, `oBUSY`=0, `oDONE`=0.
- `iSTART` is sampled at edge T. Then:
  - `oBUSY`=1 from T.
  - First RAM read at T+1.
  - `oINSTR_VALID`=1 at T+2.
- With `iINSTR_READY` held high, throughput is one instruction per cycle with no bubbles. A run of N instructions ends with its last transfer at edge T+N+1.
- `oDONE` and the `oBUSY` fall occur in the cycle after the last transfer. A new `iSTART` is accepted in that same cycle.
- If `iINSTR_READY` is low for k cycles, the stream stalls k cycles and no instruction is lost or duplicated.

## Configuration
- Macro: `GPPCU_DISPATCH_LOOP_EN`.
- **Defined:** adds input `iLOOP_COUNT` [7:0], sampled with `iSTART`.
  - The instruction segment is issued `iLOOP_COUNT`+1 times back to back.
  - The read address reloads to the start address, with no bubble between passes.
  - `oDONE` pulses only after the final pass.
- **Undefined:** the port is absent and the segment is issued once.

## Structure
- Shared package `gppcu_pkg`: `DBW`, the state enum (`IDLE`, `RUN`, `DRAIN`), and the instruction field offsets shared with the core.
- Sub-module `gppcu_dispatch_fifo`: 2-entry valid/ready FIFO with registered outputs.
- The program RAM is inferred inline.

## Test plan
- **Basic run:** load addresses 0..3 with 0xA0..0xA3; start with address 0, count 4, ready=1 → VALID at T+2, data 0xA0..0xA3 on consecutive cycles, `oDONE` at T+6.
- **Back-pressure:** same program, ready toggling 1,0,0,1,… → exactly 4 transfers, in order, with data held stable across stalls.
- **Wrap and zero count:**
  - Start at address 255 with count 3 → data from addresses 255, 0, 1.
  - Start with count 0 → `oDONE` at T+1 and VALID never asserted.
- **Busy rejection:** `iSTART` and `iPROG_WR` during a run → no effect on the stream or the RAM; the next run reads the old data.
- **Reset mid-run:** assert `iARST` after 2 transfers of 6 → all outputs 0 immediately; a fresh run from the same address replays from the first instruction.
- **Loop (`GPPCU_DISPATCH_LOOP_EN`):** count 3, `iLOOP_COUNT`=2 → 9 transfers (A,B,C repeated 3 times) with ready=1, no bubbles, one `oDONE`.
